// File: rtl/seq_decoder_if.sv
// Command/status bundle for seq_decoder: the master drives commands and
// select data, and the slave returns the registered decode and status.
interface seq_decoder_if #(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) ();
  localparam int OUT_W = 2 ** SEL_W;

  logic               en;
  logic               load;
  logic               stop;
  logic [1:0]         mode;
  logic [SEL_W-1:0]   sel_in;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   out_dec;
  logic [SEL_W-1:0]   cur_sel;
  logic               busy;
  logic               wrap;

  modport master (
    output en, load, stop, mode, sel_in, dwell,
    input  out_dec, cur_sel, busy, wrap
  );

  modport slave (
    input  en, load, stop, mode, sel_in, dwell,
    output out_dec, cur_sel, busy, wrap
  );
endinterface

// File: rtl/seq_decoder.sv
// Registered one-hot decoder with three drive modes: latched, timed one-shot
// pulse, and auto-scan with a per-index dwell count.
module seq_decoder #(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  seq_decoder_if.slave bus
);
  localparam int OUT_W = 2 ** SEL_W;

  localparam logic [1:0] MODE_LATCH = 2'b00;
  localparam logic [1:0] MODE_SCAN  = 2'b01;
  localparam logic [1:0] MODE_PULSE = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  typedef enum logic [1:0] {IDLE, HOLD, SCAN, PULSE} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic [OUT_W-1:0]   out_dec_q, out_dec_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic               dec_on;

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    dwell_d   = dwell_q;
    dcnt_d    = dcnt_q;
    wrap_d    = 1'b0;

    // stop is honoured even while disabled; load and sequencing are frozen by en
    if (bus.stop) begin
      state_d = IDLE;
    end else if (!bus.en) begin
      state_d = state_q;
    end else if (bus.load) begin
      case (bus.mode)
        MODE_LATCH: begin
          cur_sel_d = bus.sel_in;
          state_d   = HOLD;
        end
        MODE_SCAN: begin
          cur_sel_d = bus.sel_in;
          dwell_d   = bus.dwell;
          dcnt_d    = '0;
          state_d   = SCAN;
        end
        MODE_PULSE: begin
          cur_sel_d = bus.sel_in;
          dwell_d   = bus.dwell;
          dcnt_d    = '0;
          state_d   = PULSE;
        end
        MODE_CLEAR: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      case (state_q)
        SCAN: begin
          if (dcnt_q == dwell_q) begin
            dcnt_d    = '0;
            cur_sel_d = cur_sel_q + SEL_W'(1);
            wrap_d    = (cur_sel_q == {SEL_W{1'b1}});
          end else begin
            dcnt_d = dcnt_q + DWELL_W'(1);
          end
        end
        PULSE: begin
          if (dcnt_q == dwell_q) begin
            dcnt_d  = '0;
            state_d = IDLE;
          end else begin
            dcnt_d = dcnt_q + DWELL_W'(1);
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    busy_d = (state_d == SCAN) || (state_d == PULSE);
  end

  // Whenever an output is shown it is the decode of the next cur_sel.
  assign dec_on = bus.en && (state_d != IDLE);

  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
    assign out_dec_d[gi] = dec_on && (cur_sel_d == SEL_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_sel_q <= '0;
      dwell_q   <= '0;
      dcnt_q    <= '0;
      out_dec_q <= '0;
      busy_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      dwell_q   <= dwell_d;
      dcnt_q    <= dcnt_d;
      out_dec_q <= out_dec_d;
      busy_q    <= busy_d;
      wrap_q    <= wrap_d;
    end
  end

  assign bus.out_dec = out_dec_q;
  assign bus.cur_sel = cur_sel_q;
  assign bus.busy    = busy_q;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_seq_decoder.sv
// Scoreboard bench for seq_decoder: stimulus queues the expected outputs for
// each edge and a negedge monitor pops and compares them against two instances.
module tb_seq_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       load = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] sel = 4'd0;
  logic [7:0] dwell = 8'd0;

  typedef struct {
    int          due;
    logic [15:0] out_dec;
    logic [3:0]  cur_sel;
    logic        busy;
    logic        wrap;
    bit          which;
  } exp_t;

  exp_t  sb[$];
  string nm_q[$];
  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;

  seq_decoder_if #(.SEL_W(4), .DWELL_W(8)) b1 ();
  seq_decoder_if #(.SEL_W(2), .DWELL_W(1)) b2 ();

  assign b1.en     = en;
  assign b1.load   = load;
  assign b1.stop   = stop;
  assign b1.mode   = mode;
  assign b1.sel_in = sel;
  assign b1.dwell  = dwell;
  assign b2.en     = en;
  assign b2.load   = load;
  assign b2.stop   = stop;
  assign b2.mode   = mode;
  assign b2.sel_in = sel[1:0];
  assign b2.dwell  = dwell[0:0];

  seq_decoder #(.SEL_W(4), .DWELL_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  seq_decoder #(.SEL_W(2), .DWELL_W(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: compare every entry whose edge has already happened.
  exp_t        e;
  string       nm;
  logic [15:0] a_out;
  logic [3:0]  a_sel;
  logic        a_busy, a_wrap;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e  = sb.pop_front();
      nm = nm_q.pop_front();
      if (e.which) begin
        a_out  = {12'd0, b2.out_dec};
        a_sel  = {2'd0, b2.cur_sel};
        a_busy = b2.busy;
        a_wrap = b2.wrap;
      end else begin
        a_out  = b1.out_dec;
        a_sel  = b1.cur_sel;
        a_busy = b1.busy;
        a_wrap = b1.wrap;
      end
      n_vec++;
      if (a_out !== e.out_dec || a_sel !== e.cur_sel || a_busy !== e.busy || a_wrap !== e.wrap) begin
        n_err++;
        $display("FAIL %s (dut%0d cyc %0d): got out_dec=%h cur_sel=%0d busy=%b wrap=%b, want out_dec=%h cur_sel=%0d busy=%b wrap=%b",
                 nm, e.which ? 2 : 1, cyc, a_out, a_sel, a_busy, a_wrap, e.out_dec, e.cur_sel, e.busy, e.wrap);
      end else begin
        $display("vec %0d %s dut%0d out_dec=%h cur_sel=%0d busy=%b wrap=%b ok",
                 n_vec, nm, e.which ? 2 : 1, a_out, a_sel, a_busy, a_wrap);
      end
    end
  end

  task automatic push(input string name, input logic [15:0] eo, input logic [3:0] es,
                      input logic eb, input logic ew, input bit which);
    exp_t x;
    x.due = cyc + 1;
    x.out_dec = eo;
    x.cur_sel = es;
    x.busy = eb;
    x.wrap = ew;
    x.which = which;
    sb.push_back(x);
    nm_q.push_back(name);
  endtask

  // Expect these outputs after the coming edge; strobes drop afterwards.
  task automatic tick(input string name, input logic [15:0] eo, input logic [3:0] es,
                      input logic eb, input logic ew, input bit which = 1'b0);
    push(name, eo, es, eb, ew, which);
    @(negedge clk);
    load = 1'b0;
    stop = 1'b0;
  endtask

  task automatic ld(input logic [1:0] m, input logic [3:0] s, input logic [7:0] d);
    load  = 1'b1;
    mode  = m;
    sel   = s;
    dwell = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with a load pending
    rst_n = 1'b0;
    ld(2'b00, 4'd9, 8'd0);
    tick("rst0", 16'h0000, 4'd0, 1'b0, 1'b0);
    ld(2'b00, 4'd9, 8'd0);
    tick("rst1", 16'h0000, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick("idle", 16'h0000, 4'd0, 1'b0, 1'b0);

    // LATCH and enable gap
    ld(2'b00, 4'd9, 8'd0);
    tick("latch", 16'h0200, 4'd9, 1'b0, 1'b0);
    tick("hold", 16'h0200, 4'd9, 1'b0, 1'b0);
    en = 1'b0;
    repeat (3) tick("en_gap", 16'h0000, 4'd9, 1'b0, 1'b0);
    en = 1'b1;
    tick("en_resume", 16'h0200, 4'd9, 1'b0, 1'b0);
    en = 1'b0;
    ld(2'b00, 4'd3, 8'd0);
    tick("ld_gated", 16'h0000, 4'd9, 1'b0, 1'b0);
    en = 1'b1;
    tick("ld_ignored", 16'h0200, 4'd9, 1'b0, 1'b0);

    // SCAN from 14, dwell 1, wrapping through 0; dwell changed mid-scan
    ld(2'b01, 4'd14, 8'd1);
    tick("scan_ld", 16'h4000, 4'd14, 1'b1, 1'b0);
    dwell = 8'd5;
    tick("scan14", 16'h4000, 4'd14, 1'b1, 1'b0);
    tick("scan15a", 16'h8000, 4'd15, 1'b1, 1'b0);
    tick("scan15b", 16'h8000, 4'd15, 1'b1, 1'b0);
    tick("scan_wrap", 16'h0001, 4'd0, 1'b1, 1'b1);
    tick("scan0b", 16'h0001, 4'd0, 1'b1, 1'b0);
    tick("scan1a", 16'h0002, 4'd1, 1'b1, 1'b0);
    tick("scan1b", 16'h0002, 4'd1, 1'b1, 1'b0);
    en = 1'b0;
    tick("scan_frz", 16'h0000, 4'd1, 1'b1, 1'b0);
    en = 1'b1;
    tick("scan_res", 16'h0004, 4'd2, 1'b1, 1'b0);

    // Restart mid-scan at 3 with dwell 0
    ld(2'b01, 4'd3, 8'd0);
    tick("rescan3", 16'h0008, 4'd3, 1'b1, 1'b0);
    tick("d0_4", 16'h0010, 4'd4, 1'b1, 1'b0);
    tick("d0_5", 16'h0020, 4'd5, 1'b1, 1'b0);
    stop = 1'b1;
    tick("stop", 16'h0000, 4'd5, 1'b0, 1'b0);
    tick("stop_idle", 16'h0000, 4'd5, 1'b0, 1'b0);

    // PULSE sel 5 dwell 3: four cycles high
    ld(2'b10, 4'd5, 8'd3);
    tick("pulse1", 16'h0020, 4'd5, 1'b1, 1'b0);
    tick("pulse2", 16'h0020, 4'd5, 1'b1, 1'b0);
    tick("pulse3", 16'h0020, 4'd5, 1'b1, 1'b0);
    tick("pulse4", 16'h0020, 4'd5, 1'b1, 1'b0);
    tick("pulse_end", 16'h0000, 4'd5, 1'b0, 1'b0);

    // stop beats a simultaneous SCAN load
    stop = 1'b1;
    ld(2'b01, 4'd7, 8'd0);
    tick("stop_ld", 16'h0000, 4'd5, 1'b0, 1'b0);
    tick("no_scan", 16'h0000, 4'd5, 1'b0, 1'b0);

    // CLEAR during PULSE
    ld(2'b10, 4'd2, 8'd10);
    tick("pulse_c1", 16'h0004, 4'd2, 1'b1, 1'b0);
    tick("pulse_c2", 16'h0004, 4'd2, 1'b1, 1'b0);
    ld(2'b11, 4'd0, 8'd0);
    tick("clear", 16'h0000, 4'd2, 1'b0, 1'b0);
    tick("clear_idle", 16'h0000, 4'd2, 1'b0, 1'b0);

    // stop honoured while disabled
    ld(2'b00, 4'd6, 8'd0);
    tick("latch6", 16'h0040, 4'd6, 1'b0, 1'b0);
    en = 1'b0;
    stop = 1'b1;
    tick("stop_en0", 16'h0000, 4'd6, 1'b0, 1'b0);
    en = 1'b1;
    tick("stopped", 16'h0000, 4'd6, 1'b0, 1'b0);

    // Maximum dwell: 256 cycles high
    ld(2'b10, 4'd1, 8'd255);
    tick("pmax_ld", 16'h0002, 4'd1, 1'b1, 1'b0);
    repeat (255) tick("pmax", 16'h0002, 4'd1, 1'b1, 1'b0);
    tick("pmax_end", 16'h0000, 4'd1, 1'b0, 1'b0);

    // Reset mid-scan
    ld(2'b01, 4'd8, 8'd0);
    tick("scan8", 16'h0100, 4'd8, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick("rst_mid", 16'h0000, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Small instance: scan from 0 dwell 1; large one gets no wrap at start 0
    ld(2'b01, 4'd0, 8'd1);
    push("s0_nowrap", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b0);
    tick("p2_0a", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b1);
    tick("p2_0b", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b1);
    tick("p2_1a", 16'h0002, 4'd1, 1'b1, 1'b0, 1'b1);
    tick("p2_1b", 16'h0002, 4'd1, 1'b1, 1'b0, 1'b1);
    tick("p2_2a", 16'h0004, 4'd2, 1'b1, 1'b0, 1'b1);
    tick("p2_2b", 16'h0004, 4'd2, 1'b1, 1'b0, 1'b1);
    tick("p2_3a", 16'h0008, 4'd3, 1'b1, 1'b0, 1'b1);
    tick("p2_3b", 16'h0008, 4'd3, 1'b1, 1'b0, 1'b1);
    tick("p2_wrap", 16'h0001, 4'd0, 1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left in scoreboard, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
